// File: rtl/ram_stream_master_pkg.sv
// Shared types for ram_stream_master: FSM state encoding and session mode constants.
package ram_stream_master_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT_IN = 3'd1,
      S_WR_ACC  = 3'd2,
      S_RD_ACC  = 3'd3,
      S_RD_OUT  = 3'd4,
      S_GAP     = 3'd5,
      S_FIN     = 3'd6
   } state_e;

   localparam logic MODE_WR = 1'b0;
   localparam logic MODE_RD = 1'b1;

endpackage

// File: rtl/ram_stream_master_timer.sv
// Access watchdog: reloads while load is high, counts down while run is high,
// expire asserts on the TIMEOUT-th consecutive run cycle. Used only with RAM_MASTER_TIMEOUT_EN.
module ram_stream_master_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic run,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (run && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = run && (cnt_q == '0);

endmodule

// File: rtl/ram_stream_master.sv
// Stream-to-RAM session master for ram_full: LEN words written from s_* or read out to m_*.
// Optional access watchdog enabled by defining RAM_MASTER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no session; waits for start
// WAIT_IN | write session, waiting for an s_* word
// WR_ACC  | ram_we held until ram_done
// RD_ACC  | ram_re held until ram_done
// RD_OUT  | read word presented on m_*, waiting for m_ready
// GAP     | strobes low, waits for ram_done to clear, then advances address
// FIN     | one-cycle finish pulse
module ram_stream_master
   import ram_stream_master_pkg::*;
#(
   parameter int ADDR_W  = 17,
   parameter int DATA_W  = 16,
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              finish,
   output logic              err,
   output logic              ram_en,
   output logic              ram_re,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic              ram_done,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              mode_q, mode_d;
   logic              in_acc;
   logic              tmo;

   assign in_acc = (state_q == S_WR_ACC) || (state_q == S_RD_ACC);

`ifdef RAM_MASTER_TIMEOUT_EN
   logic err_q, err_d;

   ram_stream_master_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (!in_acc),
      .run    (in_acc),
      .expire (tmo)
   );

   // A completion arriving on the expiry cycle wins over the timeout.
   always_comb begin
      err_d = err_q;
      if ((state_q == S_IDLE) && start) err_d = 1'b0;
      if (tmo && !ram_done)             err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_timeout;
   assign tmo            = 1'b0;
   assign err            = 1'b0;
   assign unused_timeout = in_acc ^ (TIMEOUT > 0);
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d = base_addr;
               rem_d  = len;
               mode_d = mode;
               if (len == '0)            state_d = S_FIN;
               else if (mode == MODE_RD) state_d = S_RD_ACC;
               else                      state_d = S_WAIT_IN;
            end
         end
         S_WAIT_IN: begin
            if (s_valid) begin
               wdata_d = s_data;
               state_d = S_WR_ACC;
            end
         end
         S_WR_ACC: begin
            if (ram_done)  state_d = S_GAP;
            else if (tmo)  state_d = S_FIN;
         end
         S_RD_ACC: begin
            if (ram_done) begin
               rdata_d = ram_rdata;
               state_d = S_RD_OUT;
            end else if (tmo) begin
               state_d = S_FIN;
            end
         end
         S_RD_OUT: begin
            if (m_ready) state_d = S_GAP;
         end
         S_GAP: begin
            // Holding here until ram_done drops guarantees a clean strobe edge per access.
            if (!ram_done) begin
               addr_d = addr_q + ADDR_W'(1);
               rem_d  = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1))     state_d = S_FIN;
               else if (mode_q == MODE_RD) state_d = S_RD_ACC;
               else                        state_d = S_WAIT_IN;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         mode_q  <= MODE_WR;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         mode_q  <= mode_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign ram_en    = busy;
   assign ram_we    = (state_q == S_WR_ACC);
   assign ram_re    = (state_q == S_RD_ACC);
   assign s_ready   = (state_q == S_WAIT_IN);
   assign m_valid   = (state_q == S_RD_OUT);
   assign finish    = (state_q == S_FIN);
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign m_data    = rdata_q;

endmodule
